// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the memory arbiter and its clients: I-cache, D-cache, DMA and memory.
// master is the arbiter side; slave is the side of the caches, DMA controller and memory model.
interface mem_bus_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  localparam int LINE_W = 4 * WORD_SIZE;

  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [LINE_W-1:0]    i_data;
  logic                 i_ready;

  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [LINE_W-1:0]    d_wdata;
  logic [LINE_W-1:0]    d_rdata;
  logic                 d_ready;

  logic                 BR;
  logic                 BG;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_address;
  logic [LINE_W-1:0]    mem_wdata;
  logic [LINE_W-1:0]    mem_rdata;

  modport master (
    input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, BR, mem_rdata,
    output i_data, i_ready, d_rdata, d_ready, BG,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, BR, mem_rdata,
    input  i_data, i_ready, d_rdata, d_ready, BG,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one line-wide memory port between I-cache, D-cache and DMA (BR/BG bus handover).
// Each cache transaction is IDLE + LATENCY access cycles + one RESP cycle.
module mem_bus_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus
);
  localparam int CNT_W = 4;
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

  typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, RESP, GRANT} state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           wait_cnt;
  logic                 resp_d;
  logic                 in_access;
  logic                 last_beat;
  logic                 accept;
  logic                 enter_grant;
  logic [WORD_SIZE-1:0] acc_addr;

  assign in_access   = (state == IREAD) || (state == DREAD) || (state == DWRITE);
  assign last_beat   = (cnt == CNT_W'(LATENCY - 1));
  assign accept      = (state == IDLE) &&
                       ((next_state == IREAD) || (next_state == DREAD) || (next_state == DWRITE));
  assign enter_grant = (state != GRANT) && (next_state == GRANT);
  assign acc_addr    = (next_state == IREAD) ? bus.i_address : bus.d_address;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // A starved DMA request outranks every cache request.
        if (bus.BR && (wait_cnt >= 8'(MAX_WAIT))) next_state = GRANT;
        else if (bus.d_writeM)                    next_state = DWRITE;
        else if (bus.d_readM)                     next_state = DREAD;
        else if (bus.i_readM)                     next_state = IREAD;
        else if (bus.BR)                          next_state = GRANT;
      end
      IREAD, DREAD, DWRITE: if (last_beat) next_state = RESP;
      RESP:                 next_state = IDLE;
      GRANT:                if (!bus.BR) next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read  = (state == IREAD) || (state == DREAD);
    bus.mem_write = (state == DWRITE);
    bus.BG        = (state == GRANT);
    bus.i_ready   = (state == RESP) && !resp_d;
    bus.d_ready   = (state == RESP) && resp_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      wait_cnt        <= '0;
      resp_d          <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
      bus.i_data      <= '0;
      bus.d_rdata     <= '0;
    end else begin
      state <= next_state;

      if (accept) begin
        cnt             <= '0;
        resp_d          <= (next_state != IREAD);
        bus.mem_address <= acc_addr & ALIGN_MASK;
        bus.mem_wdata   <= bus.d_wdata;
      end else if (enter_grant) begin
        bus.mem_address <= '0;
        bus.mem_wdata   <= '0;
      end

      if (in_access) begin
        cnt <= cnt + CNT_W'(1);
        // Memory presents the line only in the final access cycle.
        if (last_beat && (state == IREAD)) bus.i_data  <= bus.mem_rdata;
        if (last_beat && (state == DREAD)) bus.d_rdata <= bus.mem_rdata;
      end

      if (!bus.BR || enter_grant)
        wait_cnt <= '0;
      else if ((state != GRANT) && (wait_cnt < 8'(MAX_WAIT)))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the single line-wide (4-word, 64-bit) memory port between the instruction cache, the data cache and the DMA controller.
- Caches issue line reads and line writes. The arbiter drives memory for a fixed LATENCY, then returns the line with a one-cycle ready pulse.
- The DMA controller obtains the whole memory bus through a BR/BG handshake. While BG is high the arbiter drives no memory commands.
- Sits between the two caches and the memory model, next to the DMA controller.

Parameters:
- WORD_SIZE, 16, bits per word; a line is 4*WORD_SIZE.
- LATENCY, 4, memory access cycles per transaction (1..15).
- MAX_WAIT, 8, cycles BR may be held ungranted before DMA gets top priority (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_readM  in  1  I-cache line read request (level, held until i_ready)
- i_address  in  WORD_SIZE  I-cache address
- i_data  out  4*WORD_SIZE  line returned to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_readM  in  1  D-cache line read request (level)
- d_writeM  in  1  D-cache line write request (level)
- d_address  in  WORD_SIZE  D-cache address
- d_wdata  in  4*WORD_SIZE  line to write
- d_rdata  out  4*WORD_SIZE  line returned to D-cache
- d_ready  out  1  one-cycle completion pulse to D-cache (reads and writes)
- BR  in  1  DMA bus request
- BG  out  1  DMA bus grant
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_address  out  WORD_SIZE  line-aligned address, low 2 bits = 00
- mem_wdata  out  4*WORD_SIZE  write line
- mem_rdata  in  4*WORD_SIZE  read line, valid in the last LATENCY cycle

Behaviour:
- States: IDLE, IREAD, DREAD, DWRITE, RESP, GRANT.
- Reset: state=IDLE; all outputs 0, including i_data, d_rdata, BG and mem_*; both counters 0. Reset mid-transaction aborts it with no ready pulse and drops BG immediately at the edge.
- Request sampling: requests are sampled only in IDLE.
- Priority in IDLE:
  1. BR when wait_cnt>=MAX_WAIT
  2. d_writeM
  3. d_readM
  4. i_readM
  5. BR
- Same-cycle d_readM and d_writeM: the write wins; the read is served in a later arbitration.
- Accept: at the accepting edge, latch {address[15:2],2'b00} into mem_address and d_wdata into mem_wdata. Move to the access state with access counter cnt=0.
- Access states (IREAD/DREAD/DWRITE): mem_read or mem_write is 1 for exactly LATENCY cycles; cnt increments each cycle.
  - On the cycle cnt==LATENCY-1, mem_rdata is captured into i_data or d_rdata (reads only). The state then moves to RESP.
  - Command and address stay stable for the whole access.
- RESP: exactly one cycle. i_ready or d_ready=1, mem_read=mem_write=0. Next state is IDLE.
  - The requester must drop its request in the RESP cycle; a request still high at the IDLE edge starts a new transaction.
  - i_data and d_rdata hold their value until the next capture.
- Throughput: 1 (IDLE) + LATENCY + 1 (RESP) cycles per transaction; default 6.
- GRANT: BG=1 from the cycle after acceptance and stays high while BR=1.
  - No mem_* commands are driven; mem_address and mem_wdata are 0.
  - Cache requests wait.
  - When BR is sampled 0, BG=0 on the next cycle and the state returns to IDLE.
- wait_cnt (8-bit):
  - Increments each cycle BR=1 and state!=GRANT; saturates at MAX_WAIT.
  - Clears on entering GRANT or when BR=0.
- BR never preempts an access or RESP; it is granted only from IDLE.
- i_ready and d_ready are never high in the same cycle. BG is never high together with mem_read or mem_write.

Test Plan:
- I-read only: reset, then i_readM=1 with i_address=16'h0037. Required: mem_read high for 4 cycles with mem_address=16'h0034. mem_rdata=64'h1111_2222_3333_4444 gives i_ready pulse 6 cycles after the request edge and i_data equal to that line.
- Collision: i_readM and d_readM asserted in the same cycle. Required: DREAD completes first (d_ready), then after IDLE an IREAD (i_ready); total 12 cycles.
- Write: d_writeM=1, d_address=16'h0102, d_wdata=64'hAAAA_BBBB_CCCC_DDDD. Required: mem_write for 4 cycles with mem_address=16'h0100 and mem_wdata=64'hAAAA_BBBB_CCCC_DDDD, then a d_ready pulse.
- DMA during access: BR raised mid DREAD. Required: BG=0 until after RESP and IDLE, then BG=1; BR dropped gives BG=0 one cycle later; a pending i_readM is then served.
- Starvation: d_readM and i_readM held continuously with BR=1. Required: BG asserted at the first IDLE after 8 ungranted cycles.
- Reset mid-access: reset at cnt=2 of DREAD. Required: next cycle all outputs 0, no d_ready, state IDLE; a new request then completes normally.
